pgm_ddram_rom_reader: RTL and testbench



---
 rtl/pgm_ddram_rom_reader.sv | 156 +++++++++++++++
 tb/tb_pgm_ddram_rom_reader.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pgm_ddram_rom_reader.sv
// rtl/pgm_ddram_rom_reader.sv - single-line cached 16-bit ROM reader over 64-bit DDRAM
//
// Serves 16-bit ROM fetches from a one-line (64-bit, 4 halfword) buffer and
// refills it from DDRAM on a miss with a single-beat read.
//
// Ports:
//   clk_sys, reset_n            clock, asynchronous active-low reset
//   invalidate                  level, clears the line buffer
//   rd_req, rd_addr             read strobe and ROM byte address
//   rd_busy, rd_ack, rd_data    miss in progress, data-valid pulse, halfword
//   ddram_rd, ddram_addr        DDRAM read request and 64-bit word address
//   ddram_busy                  DDRAM wait-request
//   ddram_dout, ddram_dout_ready  DDRAM read data and its valid
//   miss_count                  saturating miss counter

module pgm_ddram_rom_reader #(
    parameter logic [28:0] DDR_BASE = 29'h0600_0000,
    parameter int          ADDR_W   = 24
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              invalidate,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_busy,
    output logic              rd_ack,
    output logic [15:0]       rd_data,
    output logic              ddram_rd,
    output logic [28:0]       ddram_addr,
    input  logic              ddram_busy,
    input  logic [63:0]       ddram_dout,
    input  logic              ddram_dout_ready,
    output logic [15:0]       miss_count
);

    localparam int TAG_W = ADDR_W - 3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic             line_valid;
    logic [TAG_W-1:0] line_tag;
    logic [63:0]      line_data;
    logic [TAG_W-1:0] req_tag;
    logic [1:0]       req_sel;
    logic             inval_seen;
    logic [15:0]      miss_cnt_q;

    logic [TAG_W-1:0] rd_tag;
    logic [1:0]       rd_sel;
    logic             req_hit;
    logic             req_miss;
    logic             fill;

    // Halfword granularity: the byte lane bit carries no information.
    wire unused_addr_lsb = rd_addr[0];

    assign rd_tag     = rd_addr[ADDR_W-1:3];
    assign rd_sel     = rd_addr[2:1];
    assign rd_busy    = (state != S_IDLE);
    assign ddram_rd   = (state == S_ISSUE);
    assign miss_count = miss_cnt_q;

    always_comb begin
        state_nxt = state;
        req_hit   = 1'b0;
        req_miss  = 1'b0;
        fill      = 1'b0;
        case (state)
            S_IDLE: begin
                if (rd_req) begin
                    // A request alongside invalidate never hits: the line is being torn down.
                    if (line_valid && !invalidate && (rd_tag == line_tag)) begin
                        req_hit = 1'b1;
                    end else begin
                        req_miss  = 1'b1;
                        state_nxt = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                if (!ddram_busy) begin
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (ddram_dout_ready) begin
                    fill      = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            rd_ack     <= 1'b0;
            rd_data    <= 16'h0000;
            ddram_addr <= 29'h0;
            line_valid <= 1'b0;
            line_tag   <= '0;
            line_data  <= 64'h0;
            req_tag    <= '0;
            req_sel    <= 2'b00;
            inval_seen <= 1'b0;
            miss_cnt_q <= 16'h0000;
        end else begin
            rd_ack <= req_hit | fill;

            if (req_hit) begin
                rd_data <= line_data[{rd_sel, 4'b0000} +: 16];
            end

            if (fill) begin
                rd_data   <= ddram_dout[{req_sel, 4'b0000} +: 16];
                line_data <= ddram_dout;
                line_tag  <= req_tag;
            end

            if (req_miss) begin
                req_tag    <= rd_tag;
                req_sel    <= rd_sel;
                ddram_addr <= DDR_BASE + 29'(rd_tag);
                inval_seen <= invalidate;
                if (miss_cnt_q != 16'hFFFF) begin
                    miss_cnt_q <= miss_cnt_q + 16'd1;
                end
            end else if (invalidate) begin
                // Remembered so the refill in flight is not trusted as a valid line.
                inval_seen <= 1'b1;
            end

            if (invalidate) begin
                line_valid <= 1'b0;
            end else if (fill && !inval_seen) begin
                line_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pgm_ddram_rom_reader.sv
// tb/tb_pgm_ddram_rom_reader.sv - scoreboard testbench for pgm_ddram_rom_reader

module tb_pgm_ddram_rom_reader;

    localparam logic [28:0] BASE = 29'h0600_0000;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        invalidate = 1'b0;
    logic        rd_req = 1'b0;
    logic [23:0] rd_addr = 24'h0;
    logic        rd_busy;
    logic        rd_ack;
    logic [15:0] rd_data;
    logic        ddram_rd;
    logic [28:0] ddram_addr;
    logic        ddram_busy = 1'b0;
    logic [63:0] ddram_dout = 64'h0;
    logic        ddram_dout_ready = 1'b0;
    logic [15:0] miss_count;

    always #5 clk = ~clk;

    pgm_ddram_rom_reader dut (
        .clk_sys          (clk),
        .reset_n          (reset_n),
        .invalidate       (invalidate),
        .rd_req           (rd_req),
        .rd_addr          (rd_addr),
        .rd_busy          (rd_busy),
        .rd_ack           (rd_ack),
        .rd_data          (rd_data),
        .ddram_rd         (ddram_rd),
        .ddram_addr       (ddram_addr),
        .ddram_busy       (ddram_busy),
        .ddram_dout       (ddram_dout),
        .ddram_dout_ready (ddram_dout_ready),
        .miss_count       (miss_count)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // DDRAM contents as seen by the reader (64-bit word address -> line).
    function automatic logic [63:0] mem_word(input logic [28:0] a);
        logic [15:0] h;
        if (a == 29'h0600_0020) return 64'h4444_3333_2222_1111;
        h = a[15:0] ^ a[28:13];
        return {h ^ 16'hC3A5, h + 16'd7, ~h, h ^ 16'h5A5A};
    endfunction

    function automatic logic [15:0] exp_half(input logic [23:0] a);
        logic [63:0] w;
        w = mem_word(BASE + 29'(a[23:3]));
        return w[a[2:1]*16 +: 16];
    endfunction

    // Reference model state
    logic [15:0] exp_data_q[$];
    logic [28:0] exp_addr_q[$];
    bit          m_valid = 0;
    logic [20:0] m_tag = '0;
    logic [20:0] m_pend_tag = '0;
    bit          m_inval_seen = 0;
    logic [15:0] m_miss = 16'h0;
    int          n_issued = 0;

    // DDRAM responder
    int lat = 5;
    int busy_hold = 0;
    bit busy_rand = 0;
    bit resp_pending = 0;

    initial begin
        logic [28:0] a;
        forever begin
            @(negedge clk);
            if (ddram_rd && busy_hold > 0) begin
                ddram_busy = 1'b1;
                busy_hold--;
            end else if (ddram_rd && busy_rand) begin
                ddram_busy = ($urandom_range(0, 2) == 0);
            end else begin
                ddram_busy = 1'b0;
            end
            if (ddram_rd && !ddram_busy) begin
                a = ddram_addr;
                resp_pending = 1;
                @(negedge clk);
                repeat (lat - 1) @(negedge clk);
                ddram_dout_ready = 1'b1;
                ddram_dout = mem_word(a);
                @(negedge clk);
                ddram_dout_ready = 1'b0;
                ddram_dout = {$urandom, $urandom};
                resp_pending = 0;
            end
        end
    end

    // Monitor: pops the scoreboards whenever the DUT presents data or a DDRAM request.
    int rd_run = 0;
    int last_run = 0;
    int n_accept = 0;

    always @(negedge clk) begin
        #2;
        if (rd_ack) begin
            if (exp_data_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_ack: got rd_data %0h expected no ack", rd_data);
            end else begin
                check("rd_data", rd_data, exp_data_q.pop_front());
            end
        end
        if (ddram_rd) begin
            rd_run++;
            if (exp_addr_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_ddram_rd: got addr %0h expected no request", ddram_addr);
            end else begin
                check("ddram_addr", ddram_addr, exp_addr_q[0]);
            end
            if (!ddram_busy) begin
                last_run = rd_run;
                rd_run = 0;
                n_accept++;
                if (exp_addr_q.size() != 0) void'(exp_addr_q.pop_front());
            end
        end
    end

    task automatic req_begin(input logic [23:0] a, input bit inv, output bit miss);
        logic [20:0] t;
        t = a[23:3];
        miss = !(m_valid && !inv && (t == m_tag));
        rd_req = 1'b1;
        rd_addr = a;
        invalidate = inv;
        exp_data_q.push_back(exp_half(a));
        if (miss) begin
            exp_addr_q.push_back(BASE + 29'(t));
            if (m_miss != 16'hFFFF) m_miss++;
            m_inval_seen = inv;
            m_pend_tag = t;
            n_issued++;
        end
        if (inv) m_valid = 0;
        @(negedge clk);
        rd_req = 1'b0;
        invalidate = 1'b0;
        if (!miss) begin
            check("hit_ack", rd_ack, 1);
            check("hit_busy", rd_busy, 0);
        end else begin
            check("miss_busy", rd_busy, 1);
        end
    endtask

    task automatic wait_idle(input bit poke);
        int n;
        n = 0;
        while (1) begin
            rd_req = 1'b0;
            invalidate = 1'b0;
            if (!rd_busy) break;
            if (n >= 300) begin
                tests++;
                fails++;
                $display("FAIL miss_timeout: got rd_busy %0d expected 0", rd_busy);
                break;
            end
            if (poke && $urandom_range(0, 3) == 0) begin
                rd_req = 1'b1;
                rd_addr = 24'($urandom);
            end
            if (poke && $urandom_range(0, 15) == 0) begin
                invalidate = 1'b1;
                m_inval_seen = 1;
                m_valid = 0;
            end
            @(negedge clk);
            n++;
        end
        m_valid = !m_inval_seen;
        m_tag = m_pend_tag;
        check("miss_ack", rd_ack, 1);
        check("miss_count", miss_count, m_miss);
    endtask

    task automatic issue(input logic [23:0] a, input bit inv, input bit poke);
        bit miss;
        req_begin(a, inv, miss);
        if (miss) wait_idle(poke);
    endtask

    task automatic wait_accept();
        int n0;
        int k;
        n0 = n_accept;
        k = 0;
        while (n_accept == n0 && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (n_accept == n0) begin
            tests++;
            fails++;
            $display("FAIL accept_timeout: got %0d accepts expected %0d", n_accept, n0 + 1);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rd_busy"}, rd_busy, 0);
        check({tag, "_rd_ack"}, rd_ack, 0);
        check({tag, "_rd_data"}, rd_data, 0);
        check({tag, "_ddram_rd"}, ddram_rd, 0);
        check({tag, "_ddram_addr"}, ddram_addr, 0);
        check({tag, "_miss_count"}, miss_count, 0);
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit miss;
        logic [23:0] a;
        int k;

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        reset_n = 1'b1;
        @(negedge clk);

        // First miss: single-cycle request, word 2 of the line
        lat = 5;
        issue(24'h000104, 0, 0);
        check("t1_rd_data", rd_data, 16'h3333);
        check("t1_ddram_rd_len", last_run, 1);
        check("t1_miss_count", miss_count, 1);

        // Back-to-back hits on the refilled line
        issue(24'h000100, 0, 0);
        issue(24'h000102, 0, 0);
        issue(24'h000106, 0, 0);
        check("hits_no_ddram", n_accept, 1);

        // DDRAM wait-request held for 7 cycles
        busy_hold = 7;
        issue(24'h000A32, 0, 0);
        check("busy_ddram_rd_len", last_run, 8);
        check("busy_accepts", n_accept, 2);

        // Invalidate during WAIT: data still returned, line left invalid
        req_begin(24'h001234, 0, miss);
        wait_accept();
        invalidate = 1'b1;
        m_inval_seen = 1;
        m_valid = 0;
        @(negedge clk);
        invalidate = 1'b0;
        wait_idle(0);
        issue(24'h001234, 0, 0);
        check("inval_reissue", n_accept, 4);

        // Reset during WAIT followed by a stale read return
        lat = 6;
        req_begin(24'h00ABC8, 0, miss);
        wait_accept();
        @(negedge clk);
        reset_n = 1'b0;
        exp_data_q.delete();
        exp_addr_q.delete();
        m_valid = 0;
        m_miss = 16'h0;
        #1;
        check_reset_outputs("mid_reset");
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        #1;
        check_reset_outputs("post_reset");
        k = 0;
        while ((resp_pending || ddram_dout_ready) && k < 40) begin
            @(negedge clk);
            check("stale_no_ack", rd_ack, 0);
            k++;
        end
        repeat (2) @(negedge clk);
        check("stale_idle_busy", rd_busy, 0);
        lat = 3;
        issue(24'h00ABC8, 0, 0);

        // Random traffic against the reference model
        busy_rand = 1;
        for (int i = 0; i < 300; i++) begin
            lat = $urandom_range(1, 6);
            if ($urandom_range(0, 99) < 8) begin
                invalidate = 1'b1;
                m_valid = 0;
                @(negedge clk);
                invalidate = 1'b0;
            end
            if ($urandom_range(0, 9) == 0) begin
                a = 24'($urandom);
            end else begin
                a = {16'h0040, 3'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1))};
            end
            issue(a, ($urandom_range(0, 19) == 0), 1);
        end
        busy_rand = 0;

        // Saturating miss counter
        @(negedge clk);
        dut.miss_cnt_q = 16'hFFFE;
        m_miss = 16'hFFFE;
        for (int i = 0; i < 3; i++) begin
            issue(24'h000200, 1, 0);
        end
        check("miss_saturate", miss_count, 16'hFFFF);

        repeat (10) @(negedge clk);
        check("total_accepts", n_accept, n_issued);
        check("data_q_empty", exp_data_q.size(), 0);
        check("addr_q_empty", exp_addr_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
